// File: rtl/vga_sprite_if.sv
// Register write bus for the sprite overlay: write-only, one write per cycle.
interface vga_sprite_if;
   // wr_en qualifies wr_addr/wr_data for one cycle; the sink always accepts, there is no ready.
   logic        wr_en;
   logic [5:0]  wr_addr;
   logic [15:0] wr_data;

   modport master (output wr_en, wr_addr, wr_data);
   modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/vga_sprite.sv
// 16x16 monochrome hardware sprite composited over the timing generator output,
// with a 2-stage pipeline and a per-frame sticky collision flag.
module vga_sprite #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int COMMIT_LINE = 480
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] hcnt,
   input  logic [9:0] vcnt,
   input  logic       hsync_in,
   input  logic       vsync_in,
   input  logic       r_in,
   input  logic       g_in,
   input  logic       b_in,
   vga_sprite_if.slave wr,
   output logic       hsync_out,
   output logic       vsync_out,
   output logic       r_out,
   output logic       g_out,
   output logic       b_out,
   output logic       collision
);

   localparam logic [10:0] H_LIM    = 11'(H_ACTIVE);
   localparam logic [10:0] V_LIM    = 11'(V_ACTIVE);
   localparam logic [9:0]  COMMIT_V = 10'(COMMIT_LINE);

   logic [9:0]  sh_x, sh_y, act_x, act_y;
   logic [2:0]  sh_colour, act_colour;
   logic        sh_en, act_en;
   logic [15:0] bitmap [16];
   logic        commit;

   assign commit = (hcnt == 10'd0) && (vcnt == COMMIT_V);

   // Shadow registers load from the bus; active ones only move on the commit cycle,
   // so a shadow write landing on that same cycle waits a full frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_x       <= '0;
         sh_y       <= '0;
         sh_colour  <= '0;
         sh_en      <= 1'b0;
         act_x      <= '0;
         act_y      <= '0;
         act_colour <= '0;
         act_en     <= 1'b0;
      end else begin
         if (wr.wr_en) begin
            case (wr.wr_addr)
               6'h00: sh_x <= wr.wr_data[9:0];
               6'h01: sh_y <= wr.wr_data[9:0];
               6'h02: begin
                  sh_colour <= wr.wr_data[2:0];
                  sh_en     <= wr.wr_data[3];
               end
               default: ;
            endcase
         end
         if (commit) begin
            act_x      <= sh_x;
            act_y      <= sh_y;
            act_colour <= sh_colour;
            act_en     <= sh_en;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) bitmap[i] <= '0;
      end else if (wr.wr_en && (wr.wr_addr[5:4] == 2'b01)) begin
         bitmap[wr.wr_addr[3:0]] <= wr.wr_data;
      end
   end

   // Hit test in 11 bits so X+16 / Y+16 never wraps back onto the left or top edge.
   logic [10:0] h11, v11, x11, y11;
   logic        visible, in_x, in_y, hit;
   logic [3:0]  col, row;

   assign h11     = {1'b0, hcnt};
   assign v11     = {1'b0, vcnt};
   assign x11     = {1'b0, act_x};
   assign y11     = {1'b0, act_y};
   assign visible = (h11 < H_LIM) && (v11 < V_LIM);
   assign in_x    = (h11 >= x11) && (h11 < (x11 + 11'd16));
   assign in_y    = (v11 >= y11) && (v11 < (y11 + 11'd16));
   assign hit     = act_en && in_x && in_y && visible;
   assign col     = hcnt[3:0] - act_x[3:0];
   assign row     = vcnt[3:0] - act_y[3:0];

   logic        s1_hit, s1_vis, s1_hs, s1_vs;
   logic [3:0]  s1_col;
   logic [15:0] s1_row;
   logic [2:0]  s1_rgb;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_hit <= 1'b0;
         s1_vis <= 1'b0;
         s1_hs  <= 1'b1;
         s1_vs  <= 1'b1;
         s1_col <= '0;
         s1_row <= '0;
         s1_rgb <= '0;
      end else begin
         s1_hit <= hit;
         s1_vis <= visible;
         s1_hs  <= hsync_in;
         s1_vs  <= vsync_in;
         s1_col <= col;
         s1_row <= bitmap[row];
         s1_rgb <= {r_in, g_in, b_in};
      end
   end

   logic opaque;
   logic s2_coll;

   assign opaque = s1_hit && s1_row[4'd15 - s1_col];

   // collision trails the composited pixel by one cycle; a set beats the commit clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         hsync_out <= 1'b1;
         vsync_out <= 1'b1;
         r_out     <= 1'b0;
         g_out     <= 1'b0;
         b_out     <= 1'b0;
         s2_coll   <= 1'b0;
         collision <= 1'b0;
      end else begin
         hsync_out <= s1_hs;
         vsync_out <= s1_vs;
         {r_out, g_out, b_out} <= opaque ? act_colour : s1_rgb;
         s2_coll   <= opaque && s1_vis && (s1_rgb != 3'b000);
         if (s2_coll) begin
            collision <= 1'b1;
         end else if (commit) begin
            collision <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vga_sprite.sv
// Directed bench for vga_sprite: reset, sync delay, sprite placement, shadow commit,
// edge clipping, collision and ignored writes.
module tb_vga_sprite;

   logic       clk;
   logic       rst;
   logic [9:0] hcnt, vcnt;
   logic       hsync_in, vsync_in;
   logic [2:0] bg;
   logic       hsync_out, vsync_out, r_out, g_out, b_out, collision;
   int         passed;
   int         total;
   int         failed;

   vga_sprite_if bus ();

   vga_sprite dut (
      .clk       (clk),
      .rst       (rst),
      .hcnt      (hcnt),
      .vcnt      (vcnt),
      .hsync_in  (hsync_in),
      .vsync_in  (vsync_in),
      .r_in      (bg[2]),
      .g_in      (bg[1]),
      .b_in      (bg[0]),
      .wr        (bus),
      .hsync_out (hsync_out),
      .vsync_out (vsync_out),
      .r_out     (r_out),
      .g_out     (g_out),
      .b_out     (b_out),
      .collision (collision)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic idle();
      hcnt     = 10'd700;
      vcnt     = 10'd500;
      bg       = 3'b000;
      hsync_in = 1'b1;
      vsync_in = 1'b1;
   endtask

   task automatic write_reg(input logic [5:0] a, input logic [15:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      tick();
      bus.wr_en   = 1'b0;
   endtask

   task automatic commit();
      hcnt = 10'd0;
      vcnt = 10'd480;
      tick();
      idle();
   endtask

   // Drives one pixel, then one idle pixel; after the second edge the output is that pixel.
   task automatic pixel(input string tag, input logic [9:0] h, input logic [9:0] v,
                        input logic [2:0] b, input logic [2:0] exp);
      hcnt = h;
      vcnt = v;
      bg   = b;
      tick();
      idle();
      tick();
      chk(tag, {r_out, g_out, b_out}, exp);
   endtask

   task automatic coll(input string tag, input logic exp);
      tick();
      chk(tag, {2'b00, collision}, {2'b00, exp});
   endtask

   logic [7:0] pat;
   logic       prev;

   initial begin
      passed      = 0;
      total       = 0;
      failed      = 0;
      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      idle();

      // reset with random inputs
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         hcnt        = 10'($urandom_range(0, 1023));
         vcnt        = 10'($urandom_range(0, 1023));
         hsync_in    = 1'($urandom_range(0, 1));
         vsync_in    = 1'($urandom_range(0, 1));
         bg          = 3'($urandom_range(0, 7));
         bus.wr_en   = 1'($urandom_range(0, 1));
         bus.wr_addr = 6'($urandom_range(0, 63));
         bus.wr_data = 16'($urandom_range(0, 65535));
         tick();
         chk($sformatf("rst_hs%0d", i), {2'b00, hsync_out}, 3'b001);
         chk($sformatf("rst_vs%0d", i), {2'b00, vsync_out}, 3'b001);
         chk($sformatf("rst_rgb%0d", i), {r_out, g_out, b_out}, 3'b000);
         chk($sformatf("rst_coll%0d", i), {2'b00, collision}, 3'b000);
      end
      rst       = 1'b0;
      bus.wr_en = 1'b0;
      idle();

      // hsync_out follows hsync_in two edges later; reset leaves a 1 in flight
      pat  = 8'b1011_0010;
      prev = 1'b1;
      for (int i = 0; i < 8; i++) begin
         hsync_in = pat[i];
         tick();
         chk($sformatf("hs_delay%0d", i), {2'b00, hsync_out}, {2'b00, prev});
         prev = pat[i];
      end
      idle();
      tick();
      tick();

      // basic sprite at (100,50), colour 101, row0 = 8001
      write_reg(6'h00, 16'd100);
      write_reg(6'h01, 16'd50);
      write_reg(6'h02, 16'h000D);
      write_reg(6'h10, 16'h8001);
      commit();
      pixel("basic_left_black", 10'd100, 10'd50, 3'b000, 3'b101);
      coll("coll_black", 1'b0);
      pixel("basic_right", 10'd115, 10'd50, 3'b000, 3'b101);
      pixel("mid_101", 10'd101, 10'd50, 3'b010, 3'b010);
      pixel("mid_114", 10'd114, 10'd50, 3'b011, 3'b011);
      pixel("left_outside", 10'd99, 10'd50, 3'b110, 3'b110);
      pixel("right_outside", 10'd116, 10'd50, 3'b001, 3'b001);
      pixel("row51", 10'd100, 10'd51, 3'b100, 3'b100);
      pixel("row65", 10'd115, 10'd65, 3'b111, 3'b111);
      coll("coll_no_opaque", 1'b0);

      // collision set, held, cleared on commit
      pixel("coll_px", 10'd115, 10'd50, 3'b010, 3'b101);
      coll("coll_set", 1'b1);
      tick();
      tick();
      chk("coll_hold", {2'b00, collision}, 3'b001);
      write_reg(6'h05, 16'hFFFF);
      write_reg(6'h03, 16'h00FF);
      commit();
      chk("coll_clear", {2'b00, collision}, 3'b000);

      // ignored addresses left the registers alone
      pixel("ignored_x", 10'd100, 10'd50, 3'b000, 3'b101);
      pixel("ignored_row", 10'd107, 10'd50, 3'b001, 3'b001);

      // shadow X write mid-frame takes effect next frame
      hcnt = 10'd300;
      vcnt = 10'd100;
      write_reg(6'h00, 16'd200);
      idle();
      pixel("shadow_old", 10'd100, 10'd50, 3'b000, 3'b101);
      pixel("shadow_new_early", 10'd200, 10'd50, 3'b010, 3'b010);
      commit();
      pixel("shadow_new", 10'd200, 10'd50, 3'b000, 3'b101);
      pixel("shadow_old_gone", 10'd100, 10'd50, 3'b001, 3'b001);

      // write on the commit cycle waits one more frame
      hcnt        = 10'd0;
      vcnt        = 10'd480;
      bus.wr_en   = 1'b1;
      bus.wr_addr = 6'h00;
      bus.wr_data = 16'd300;
      tick();
      bus.wr_en   = 1'b0;
      idle();
      pixel("commit_wr_still", 10'd200, 10'd50, 3'b000, 3'b101);
      pixel("commit_wr_not_yet", 10'd300, 10'd50, 3'b010, 3'b010);
      commit();
      pixel("commit_wr_next", 10'd300, 10'd50, 3'b000, 3'b101);

      // edge clip at (630,470), solid bitmap, colour 011
      write_reg(6'h00, 16'd630);
      write_reg(6'h01, 16'd470);
      write_reg(6'h02, 16'h000B);
      for (int r = 0; r < 16; r++) write_reg(6'(16 + r), 16'hFFFF);
      commit();
      pixel("clip_tl", 10'd630, 10'd470, 3'b000, 3'b011);
      pixel("clip_br", 10'd639, 10'd479, 3'b000, 3'b011);
      pixel("clip_mid", 10'd635, 10'd475, 3'b000, 3'b011);
      pixel("clip_left", 10'd629, 10'd470, 3'b001, 3'b001);
      pixel("clip_above", 10'd630, 10'd469, 3'b010, 3'b010);
      pixel("clip_h640", 10'd640, 10'd470, 3'b100, 3'b100);
      pixel("clip_h645", 10'd645, 10'd470, 3'b101, 3'b101);
      pixel("clip_v480", 10'd630, 10'd480, 3'b110, 3'b110);
      pixel("clip_v485", 10'd630, 10'd485, 3'b001, 3'b001);
      pixel("clip_nowrap_h0", 10'd0, 10'd470, 3'b010, 3'b010);
      pixel("clip_nowrap_h5", 10'd5, 10'd470, 3'b010, 3'b010);
      pixel("clip_nowrap_h3", 10'd3, 10'd479, 3'b001, 3'b001);

      // disabled sprite: background passes, no collision
      write_reg(6'h02, 16'h0003);
      commit();
      pixel("dis_px", 10'd635, 10'd475, 3'b111, 3'b111);
      coll("coll_disabled", 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
